regfile_writeback_ctrl: RTL and testbench

Write-back controller that drives the register file's write port. It accepts completed-instruction results from the datapath through a valid/ready handshake and buffers them in a small FIFO. It selects the destination register and the data source, and performs read-modify-write merges for byte loads (opcode 0x24) and halfword loads (opcode 0x25). It sits between the execute/memory stages and the register file, and is the only agent that asserts register-file writes.

---
 rtl/regfile_writeback_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write-back controller.
// Buffers completed-instruction results in a small FIFO, picks the destination
// register and data source, and performs read-modify-write merges for byte
// (0x24) and halfword (0x25) loads. It is the only agent driving rf_wr_en.
module regfile_writeback_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_reg_dst,
  input  logic        in_mem_to_reg,
  input  logic [31:0] in_alu_data,
  input  logic [31:0] in_mem_data,
  output logic        rf_rd_en,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        busy,
  output logic [15:0] wr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 83;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_MRG  = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  localparam logic [5:0] OP_LB = 6'h24;
  localparam logic [5:0] OP_LH = 6'h25;

  // FIFO storage and bookkeeping
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  // FSM and registered outputs
  logic [1:0]  state_reg;
  logic [4:0]  dest_reg;
  logic [31:0] src_reg;
  logic        half_reg;
  logic        rf_rd_en_reg;
  logic [4:0]  rf_rd_addr_reg;
  logic        rf_wr_en_reg;
  logic [4:0]  rf_wr_addr_reg;
  logic [31:0] rf_wr_data_reg;
  logic [15:0] wr_count_reg;

  // Head-entry decode
  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_entry;
  logic [5:0]    head_opcode;
  logic [4:0]    head_rt;
  logic [4:0]    head_rd;
  logic          head_reg_write;
  logic          head_reg_dst;
  logic          head_mem_to_reg;
  logic [31:0]   head_alu;
  logic [31:0]   head_mem;
  logic [4:0]    head_dest;
  logic [31:0]   head_src;
  logic          head_valid;
  logic          head_drop;
  logic          head_merge;
  logic          push;
  logic          pop;

  assign in_entry = {in_opcode, in_rt, in_rd, in_reg_write, in_reg_dst,
                     in_mem_to_reg, in_alu_data, in_mem_data};

  assign head_entry      = fifo_mem[rd_ptr_reg];
  assign head_opcode     = head_entry[82:77];
  assign head_rt         = head_entry[76:72];
  assign head_rd         = head_entry[71:67];
  assign head_reg_write  = head_entry[66];
  assign head_reg_dst    = head_entry[65];
  assign head_mem_to_reg = head_entry[64];
  assign head_alu        = head_entry[63:32];
  assign head_mem        = head_entry[31:0];

  assign head_dest  = head_reg_dst ? head_rd : head_rt;
  assign head_src   = head_mem_to_reg ? head_mem : head_alu;
  assign head_valid = (count_reg != '0);
  // r0 is hard-wired zero, so writes to it are discarded like reg_write=0
  assign head_drop  = !head_reg_write || (head_dest == 5'd0);
  assign head_merge = (head_opcode == OP_LB) || (head_opcode == OP_LH);

  assign in_ready = (count_reg != FULL_COUNT);
  assign push     = in_valid && in_ready;
  // Drops leave in the IDLE decision cycle; real writes leave at the end of WR
  assign pop      = ((state_reg == ST_IDLE) && head_valid && head_drop) ||
                    (state_reg == ST_WR);

  assign rf_rd_en   = rf_rd_en_reg;
  assign rf_rd_addr = rf_rd_addr_reg;
  assign rf_wr_en   = rf_wr_en_reg;
  assign rf_wr_addr = rf_wr_addr_reg;
  assign rf_wr_data = rf_wr_data_reg;
  assign wr_count   = wr_count_reg;
  assign busy       = head_valid || (state_reg != ST_IDLE);

  // Entry storage: captured on push, contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_entry;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Write-back sequencer: IDLE decides, RD fetches old value, MRG merges, WR strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      dest_reg       <= '0;
      src_reg        <= '0;
      half_reg       <= 1'b0;
      rf_rd_en_reg   <= 1'b0;
      rf_rd_addr_reg <= '0;
      rf_wr_en_reg   <= 1'b0;
      rf_wr_addr_reg <= '0;
      rf_wr_data_reg <= '0;
      wr_count_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (head_valid && !head_drop) begin
            if (head_merge) begin
              dest_reg       <= head_dest;
              src_reg        <= head_src;
              half_reg       <= (head_opcode == OP_LH);
              rf_rd_en_reg   <= 1'b1;
              rf_rd_addr_reg <= head_dest;
              state_reg      <= ST_RD;
            end else begin
              rf_wr_en_reg   <= 1'b1;
              rf_wr_addr_reg <= head_dest;
              rf_wr_data_reg <= head_src;
              state_reg      <= ST_WR;
            end
          end
        end
        ST_RD: begin
          rf_rd_en_reg <= 1'b0;
          state_reg    <= ST_MRG;
        end
        ST_MRG: begin
          // Upper bits always come from the old register value, no sign extension
          rf_wr_data_reg <= half_reg ? {rf_rd_data[31:16], src_reg[15:0]}
                                     : {rf_rd_data[31:8],  src_reg[7:0]};
          rf_wr_addr_reg <= dest_reg;
          rf_wr_en_reg   <= 1'b1;
          state_reg      <= ST_WR;
        end
        default: begin
          rf_wr_en_reg <= 1'b0;
          wr_count_reg <= wr_count_reg + 16'd1;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed bench for regfile_writeback_ctrl: full writes, byte/halfword
// merges, drops, back-pressure ordering and reset during a merge.
module tb_regfile_writeback_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_reg_dst;
  logic        in_mem_to_reg;
  logic [31:0] in_alu_data;
  logic [31:0] in_mem_data;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        busy;
  logic [15:0] wr_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int overlap = 0;

  logic [31:0] rf_model [32];
  logic [4:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];

  regfile_writeback_ctrl #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_reg_dst   (in_reg_dst),
    .in_mem_to_reg(in_mem_to_reg),
    .in_alu_data  (in_alu_data),
    .in_mem_data  (in_mem_data),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .busy         (busy),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure write spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file read port: data valid the cycle after rf_rd_en, garbage otherwise
  always @(posedge clk) rf_rd_data <= rf_rd_en ? rf_model[rf_rd_addr] : 32'hBAD0_BAD0;

  // Port monitor on the falling edge: log writes, count reads and overlaps
  always @(negedge clk) begin
    if (rf_wr_en === 1'b1) begin
      wr_addr_q.push_back(rf_wr_addr);
      wr_data_q.push_back(rf_wr_data);
      wr_cyc_q.push_back(cyc);
      $display("write: addr=%0d data=0x%08h cycle=%0d", rf_wr_addr, rf_wr_data, cyc);
    end
    if (rf_rd_en === 1'b1) rd_pulses++;
    if (rf_wr_en === 1'b1 && rf_rd_en === 1'b1) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  task automatic push_entry(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                            input logic rw, input logic rdst, input logic m2r,
                            input logic [31:0] alu, input logic [31:0] mem);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_rt         = rt;
    in_rd         = rd;
    in_reg_write  = rw;
    in_reg_dst    = rdst;
    in_mem_to_reg = m2r;
    in_alu_data   = alu;
    in_mem_data   = mem;
    tick();
    in_valid      = 1'b0;
  endtask

  initial begin
    int base_wr;
    int base_rd;
    logic accepted;
    logic saw_full;

    for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
    rf_model[7]  = 32'h1234_5678;
    rf_model[3]  = 32'h1111_2222;
    rf_model[9]  = 32'hAAAA_AAAA;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_opcode = '0;
    in_rt = '0;
    in_rd = '0;
    in_reg_write = 1'b0;
    in_reg_dst = 1'b0;
    in_mem_to_reg = 1'b0;
    in_alu_data = '0;
    in_mem_data = '0;

    // Reset state
    tick();
    tick();
    check("rst_rd_en", rf_rd_en, 0);
    check("rst_wr_en", rf_wr_en, 0);
    check("rst_rd_addr", rf_rd_addr, 0);
    check("rst_wr_addr", rf_wr_addr, 0);
    check("rst_wr_data", rf_wr_data, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Full write via rd: strobe two cycles after the push edge
    push_entry(6'h00, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_0000);
    check("full_e1_wr_en", rf_wr_en, 0);
    check("full_e1_busy", busy, 1);
    tick();
    check("full_e2_wr_en", rf_wr_en, 1);
    check("full_e2_addr", rf_wr_addr, 5);
    check("full_e2_data", rf_wr_data, 32'hDEAD_BEEF);
    tick();
    check("full_e3_wr_en", rf_wr_en, 0);
    check("full_wr_count", wr_count, 1);
    check("full_busy_done", busy, 0);
    check("full_pulses", wr_addr_q.size(), 1);

    // Byte merge on rt=7 with mem data
    push_entry(6'h24, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 32'h9999_9999, 32'h0000_00AB);
    tick();
    check("lb_rd_en", rf_rd_en, 1);
    check("lb_rd_addr", rf_rd_addr, 7);
    check("lb_rd_no_wr", rf_wr_en, 0);
    tick();
    check("lb_mrg_rd_en", rf_rd_en, 0);
    check("lb_mrg_wr_en", rf_wr_en, 0);
    tick();
    check("lb_wr_en", rf_wr_en, 1);
    check("lb_wr_addr", rf_wr_addr, 7);
    check("lb_wr_data", rf_wr_data, 32'h1234_56AB);
    tick();
    check("lb_wr_count", wr_count, 2);

    // Halfword merge on rd=3 with ALU data
    push_entry(6'h25, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 32'hFFFF_CAFE, 32'h5555_AAAA);
    tick();
    check("lh_rd_addr", rf_rd_addr, 3);
    tick();
    tick();
    check("lh_wr_en", rf_wr_en, 1);
    check("lh_wr_addr", rf_wr_addr, 3);
    check("lh_wr_data", rf_wr_data, 32'h1111_CAFE);
    tick();
    check("lh_wr_count", wr_count, 3);

    // Drops: reg_write=0, then a merge targeting r0; each leaves in one cycle
    base_wr = wr_addr_q.size();
    base_rd = rd_pulses;
    push_entry(6'h00, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, 32'h0000_1111, 32'h0);
    push_entry(6'h24, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_00EE);
    check("drop_busy_mid", busy, 1);
    check("drop_wr_en_mid", rf_wr_en, 0);
    tick();
    check("drop_busy_after", busy, 0);
    tick();
    tick();
    check("drop_no_wr", wr_addr_q.size(), base_wr);
    check("drop_no_rd", rd_pulses, base_rd);
    check("drop_wr_count", wr_count, 3);

    // Back-pressure: four back-to-back full writes into a two-entry FIFO
    base_wr = wr_addr_q.size();
    saw_full = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid      = 1'b1;
      in_opcode     = 6'h00;
      in_rt         = 5'd0;
      in_rd         = 5'(k);
      in_reg_write  = 1'b1;
      in_reg_dst    = 1'b1;
      in_mem_to_reg = 1'b0;
      in_alu_data   = 32'h1000_0000 + 32'(k);
      in_mem_data   = 32'hEEEE_EEEE;
      accepted = 1'b0;
      for (int w = 0; w < 20 && !accepted; w++) begin
        if (in_ready === 1'b0) saw_full = 1'b1;
        accepted = (in_ready === 1'b1);
        tick();
      end
      check("bp_push_accept", accepted, 1);
    end
    in_valid = 1'b0;
    for (int w = 0; w < 40 && busy; w++) tick();
    check("bp_drain_busy", busy, 0);
    check("bp_saw_full", saw_full, 1);
    check("bp_write_total", wr_addr_q.size(), base_wr + 4);
    if (wr_addr_q.size() == base_wr + 4) begin
      for (int i = 0; i < 4; i++) begin
        check("bp_order_addr", wr_addr_q[base_wr + i], 32'(i + 1));
        check("bp_order_data", wr_data_q[base_wr + i], 32'h1000_0001 + 32'(i));
        if (i > 0) check("bp_spacing", wr_cyc_q[base_wr + i] - wr_cyc_q[base_wr + i - 1], 2);
      end
    end
    check("bp_wr_count", wr_count, 7);

    // Reset during MRG with a second entry still queued
    tick();
    base_wr = wr_addr_q.size();
    push_entry(6'h24, 5'd9, 5'd1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0077);
    push_entry(6'h00, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check("rm_rd_en", rf_rd_en, 1);
    tick();
    check("rm_mrg_rd_en", rf_rd_en, 0);
    check("rm_mrg_wr_en", rf_wr_en, 0);
    rst_n = 1'b0;
    tick();
    check("rm_wr_en", rf_wr_en, 0);
    check("rm_rd_en_after", rf_rd_en, 0);
    check("rm_wr_addr", rf_wr_addr, 0);
    check("rm_wr_data", rf_wr_data, 0);
    check("rm_rd_addr", rf_rd_addr, 0);
    check("rm_wr_count", wr_count, 0);
    check("rm_busy", busy, 0);
    check("rm_in_ready", in_ready, 1);
    rst_n = 1'b1;
    for (int w = 0; w < 6; w++) tick();
    check("rm_no_late_wr", wr_addr_q.size(), base_wr);
    check("rm_busy_idle", busy, 0);

    check("rd_wr_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
